// File: rtl/pbs_ctrl.sv
// pbs_ctrl: turn-sequencing Moore FSM that drives every control input of pbs_dp.
// Control outputs are registered decodes of the next state, so they always match state_r.
module pbs_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] p_move_in,
  input  logic [3:0] p_hp,
  input  logic [3:0] AI_hp,
  output logic [1:0] p_move,
  output logic       actr,
  output logic       target,
  output logic       app_dmg,
  output logic       stop,
  output logic       dp_rst_n,
  output logic       busy,
  output logic       p_win,
  output logic       ai_win,
  output logic [7:0] turn_cnt
);

  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_WAIT   = 4'd1,
    ST_P_SEL  = 4'd2,
    ST_P_HIT  = 4'd3,
    ST_P_CHK  = 4'd4,
    ST_AI_SEL = 4'd5,
    ST_AI_HIT = 4'd6,
    ST_AI_CHK = 4'd7,
    ST_WIN    = 4'd8,
    ST_LOSE   = 4'd9
  } state_t;

  typedef struct packed {
    logic dp_rst_n;
    logic actr;
    logic target;
    logic app_dmg;
    logic stop;
    logic busy;
    logic p_win;
    logic ai_win;
  } ctl_t;

  state_t           state_r;
  state_t           state_nxt_s;
  ctl_t             ctl_r;
  logic             go_q_r;
  logic             go_rise_s;
  logic [CNT_W-1:0] settle_cnt_r;
  logic             settle_done_s;
  logic             in_sel_s;
  logic [1:0]       p_move_r;
  logic [7:0]       turn_cnt_r;

  // Control word for a state; anything unrecognised decodes like INIT.
  function automatic ctl_t decode_ctl(input state_t st);
    ctl_t c;
    c          = ctl_t'(8'h00);
    c.dp_rst_n = 1'b1;
    c.busy     = 1'b1;
    case (st)
      ST_INIT:   c.dp_rst_n = 1'b0;
      ST_WAIT:   c.busy = 1'b0;
      ST_P_SEL:  c.target = 1'b1;
      ST_P_HIT:  begin c.target = 1'b1; c.app_dmg = 1'b1; end
      ST_P_CHK:  c.target = 1'b1;
      ST_AI_SEL: begin c.actr = 1'b1; c.stop = 1'b1; end
      ST_AI_HIT: begin c.actr = 1'b1; c.stop = 1'b1; c.app_dmg = 1'b1; end
      ST_AI_CHK: begin c.actr = 1'b1; c.stop = 1'b1; end
      ST_WIN:    begin c.busy = 1'b0; c.p_win = 1'b1; end
      ST_LOSE:   begin c.busy = 1'b0; c.ai_win = 1'b1; end
      default:   c.dp_rst_n = 1'b0;
    endcase
    return c;
  endfunction

  assign go_rise_s     = go & ~go_q_r;
  assign in_sel_s      = (state_r == ST_P_SEL) || (state_r == ST_AI_SEL);
  assign settle_done_s = (settle_cnt_r == SETTLE_LAST);

  // Next-state selection.
  always_comb begin
    state_nxt_s = ST_INIT;
    case (state_r)
      ST_INIT: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (go_rise_s) state_nxt_s = ST_P_SEL;
        else           state_nxt_s = ST_WAIT;
      end
      ST_P_SEL: begin
        if (settle_done_s) state_nxt_s = ST_P_HIT;
        else               state_nxt_s = ST_P_SEL;
      end
      ST_P_HIT: state_nxt_s = ST_P_CHK;
      ST_P_CHK: begin
        // AI_hp already reflects the hit written on the edge that ended P_HIT
        if (AI_hp == 4'd0) state_nxt_s = ST_WIN;
        else               state_nxt_s = ST_AI_SEL;
      end
      ST_AI_SEL: begin
        if (settle_done_s) state_nxt_s = ST_AI_HIT;
        else               state_nxt_s = ST_AI_SEL;
      end
      ST_AI_HIT: state_nxt_s = ST_AI_CHK;
      ST_AI_CHK: begin
        if (p_hp == 4'd0) state_nxt_s = ST_LOSE;
        else              state_nxt_s = ST_WAIT;
      end
      ST_WIN: begin
        if (go_rise_s) state_nxt_s = ST_INIT;
        else           state_nxt_s = ST_WIN;
      end
      ST_LOSE: begin
        if (go_rise_s) state_nxt_s = ST_INIT;
        else           state_nxt_s = ST_LOSE;
      end
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // State register with registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_INIT;
      ctl_r   <= decode_ctl(ST_INIT);
    end else begin
      state_r <= state_nxt_s;
      ctl_r   <= decode_ctl(state_nxt_s);
    end
  end

  // Settle counter for the select states; idles at zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_r <= {CNT_W{1'b0}};
    end else if (in_sel_s && !settle_done_s) begin
      settle_cnt_r <= settle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      settle_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // go edge detector, move latch and saturating turn counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      go_q_r     <= 1'b0;
      p_move_r   <= 2'b00;
      turn_cnt_r <= 8'd0;
    end else begin
      go_q_r <= go;
      if ((state_r == ST_WAIT) && go_rise_s) begin
        p_move_r <= p_move_in;
      end else begin
        p_move_r <= p_move_r;
      end
      if ((state_r == ST_AI_CHK) && (turn_cnt_r != 8'hFF)) begin
        turn_cnt_r <= turn_cnt_r + 8'd1;
      end else if (((state_r == ST_WIN) || (state_r == ST_LOSE)) && go_rise_s) begin
        turn_cnt_r <= 8'd0;
      end else begin
        turn_cnt_r <= turn_cnt_r;
      end
    end
  end

  assign p_move   = p_move_r;
  assign turn_cnt = turn_cnt_r;
  assign dp_rst_n = ctl_r.dp_rst_n;
  assign actr     = ctl_r.actr;
  assign target   = ctl_r.target;
  assign app_dmg  = ctl_r.app_dmg;
  assign stop     = ctl_r.stop;
  assign busy     = ctl_r.busy;
  assign p_win    = ctl_r.p_win;
  assign ai_win   = ctl_r.ai_win;

endmodule

// File: tb/tb_pbs_ctrl.sv
// Self-checking bench for pbs_ctrl: timeline-based reference model plus an HP stub
// that stands in for pbs_dp; directed scenarios followed by randomized play.
module tb_pbs_ctrl;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst, go;
  logic [1:0] p_move_in;
  logic [3:0] p_hp, AI_hp;
  logic [1:0] p_move;
  logic       actr, target, app_dmg, stop, dp_rst_n, busy, p_win, ai_win;
  logic [7:0] turn_cnt;

  always #5 clk = ~clk;

  pbs_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .go(go), .p_move_in(p_move_in),
    .p_hp(p_hp), .AI_hp(AI_hp), .p_move(p_move), .actr(actr),
    .target(target), .app_dmg(app_dmg), .stop(stop), .dp_rst_n(dp_rst_n),
    .busy(busy), .p_win(p_win), .ai_win(ai_win), .turn_cnt(turn_cnt)
  );

  // Reference model: game phase plus cycle index inside the current turn (1 = first select cycle).
  typedef enum int {PH_INIT, PH_IDLE, PH_TURN, PH_WIN, PH_LOSE} phase_t;
  phase_t     m_phase;
  int         m_t;
  logic       m_go_q;
  logic [1:0] m_p_move;
  int         m_turn;
  int         dmg_mode;  // 0 no damage, 1 random, 2 AI dies on hit, 3 player dies on hit
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  // {dp_rst_n, actr, target, app_dmg, stop, busy, p_win, ai_win}
  function automatic logic [7:0] exp_ctl();
    logic [7:0] v;
    v = 8'h00;
    case (m_phase)
      PH_INIT: v = 8'b0000_0100;
      PH_IDLE: v = 8'b1000_0000;
      PH_WIN:  v = 8'b1000_0010;
      PH_LOSE: v = 8'b1000_0001;
      default: begin
        if (m_t <= S + 2) v = {1'b1, 1'b0, 1'b1, (m_t == S + 1), 1'b0, 1'b1, 2'b00};
        else              v = {1'b1, 1'b1, 1'b0, (m_t == 2*S + 3), 1'b1, 1'b1, 2'b00};
      end
    endcase
    return v;
  endfunction

  function automatic logic [3:0] hit_hp(input logic [3:0] hp, input bit on_ai);
    int d;
    d = $urandom_range(1, 6);
    case (dmg_mode)
      1: return (int'(hp) > d) ? 4'(int'(hp) - d) : 4'd0;
      2: return on_ai ? 4'd0 : hp;
      3: return on_ai ? hp : 4'd0;
      default: return hp;
    endcase
  endfunction

  task automatic step(input logic r, input logic g, input logic [1:0] pm);
    logic rise;
    rst = r; go = g; p_move_in = pm;
    @(posedge clk);
    #1;
    rise = g & ~m_go_q;
    if (r) begin
      m_phase = PH_INIT; m_t = 0; m_p_move = 2'b00; m_turn = 0;
    end else begin
      case (m_phase)
        PH_INIT: m_phase = PH_IDLE;
        PH_IDLE: if (rise) begin m_phase = PH_TURN; m_t = 1; m_p_move = pm; end
        PH_TURN: begin
          if (m_t == S + 2 && AI_hp == 4'd0) m_phase = PH_WIN;
          else if (m_t == 2*S + 4) begin
            if (m_turn < 255) m_turn++;
            m_phase = (p_hp == 4'd0) ? PH_LOSE : PH_IDLE;
          end else m_t++;
        end
        default: if (rise) begin m_phase = PH_INIT; m_turn = 0; end
      endcase
    end
    m_go_q = r ? 1'b0 : g;
    // HP stub: fresh HP after a datapath reset, damage lands on the edge that ends each hit
    if (m_phase == PH_INIT) begin
      p_hp  = 4'($urandom_range(1, 15));
      AI_hp = 4'($urandom_range(1, 15));
    end else if (m_phase == PH_TURN && m_t == S + 2) begin
      AI_hp = hit_hp(AI_hp, 1'b1);
    end else if (m_phase == PH_TURN && m_t == 2*S + 4) begin
      p_hp = hit_hp(p_hp, 1'b0);
    end
    chk_eq("ctl", 32'({dp_rst_n, actr, target, app_dmg, stop, busy, p_win, ai_win}), 32'(exp_ctl()));
    chk_eq("p_move", 32'(p_move), 32'(m_p_move));
    chk_eq("turn_cnt", 32'(turn_cnt), 32'(m_turn));
  endtask

  initial begin
    logic g;
    m_phase = PH_INIT; m_t = 0; m_go_q = 1'b0; m_p_move = 2'b00; m_turn = 0;
    dmg_mode = 0;
    p_hp = 4'd9; AI_hp = 4'd9;
    rst = 1'b1; go = 1'b0; p_move_in = 2'b00;

    // reset held three cycles, then INIT -> WAIT
    repeat (3) step(1'b1, 1'b0, 2'b00);
    repeat (3) step(1'b0, 1'b0, 2'b00);

    // normal turn, no damage
    step(1'b0, 1'b1, 2'b10);
    repeat (11) step(1'b0, 1'b0, 2'b01);
    chk_eq("turn_one", 32'(turn_cnt), 32'd1);

    // player kills AI -> WIN, then go restarts via INIT
    dmg_mode = 2;
    step(1'b0, 1'b1, 2'b11);
    repeat (8) step(1'b0, 1'b0, 2'b00);
    chk_eq("p_win", 32'(p_win), 32'd1);
    step(1'b0, 1'b1, 2'b00);
    repeat (3) step(1'b0, 1'b0, 2'b00);

    // AI kills player -> LOSE, then go restarts via INIT
    dmg_mode = 3;
    step(1'b0, 1'b1, 2'b01);
    repeat (10) step(1'b0, 1'b0, 2'b00);
    chk_eq("ai_win", 32'(ai_win), 32'd1);
    step(1'b0, 1'b1, 2'b00);
    chk_eq("turn_clr", 32'(turn_cnt), 32'd0);
    repeat (3) step(1'b0, 1'b0, 2'b00);

    // go held high for 20 cycles with p_move_in wandering
    dmg_mode = 0;
    repeat (20) step(1'b0, 1'b1, 2'($urandom_range(0, 3)));
    repeat (3) step(1'b0, 1'b0, 2'b00);

    // extra go pulses while busy
    step(1'b0, 1'b1, 2'b10);
    repeat (8) step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    repeat (12) step(1'b0, 1'b0, 2'b00);

    // reset during AI_SEL aborts the turn
    step(1'b0, 1'b1, 2'b01);
    repeat (S + 2) step(1'b0, 1'b0, 2'b00);
    chk_eq("stop_pre", 32'(stop), 32'd1);
    step(1'b1, 1'b0, 2'b00);
    repeat (3) step(1'b0, 1'b0, 2'b00);

    // 256 completed turns saturate the counter
    repeat (256) begin
      step(1'b0, 1'b1, 2'($urandom_range(0, 3)));
      repeat (2*S + 4) step(1'b0, 1'b0, 2'b00);
    end
    chk_eq("turn_sat", 32'(turn_cnt), 32'd255);

    // randomized play
    dmg_mode = 1;
    g = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) g = ~g;
      step(1'($urandom_range(0, 299) == 0), g, 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pbs_ctrl.md
# pbs_ctrl

Turn-sequencing controller for the battle datapath `pbs_dp`. It waits for the player to confirm a move, then drives the datapath through two phases: the player attacks the AI, then the AI attacks the player. In the AI phase the datapath's random sources are frozen so the AI move is stable. After each hit the controller checks both HP values and declares a win or loss. It owns every `pbs_dp` control input.

## Interface
- `SETTLE_CYCLES`, default 2: cycles spent in each select state before the hit. Must be ≥2, because `pbs_dp` registers the trainer mux one cycle after `actr` changes.
- `clk  in  1`: system clock.
- `rst  in  1`: synchronous reset, active-high. One clock; reset is synchronous and active-high.
- `go  in  1`: player confirm button, level input. Edge-detected internally.
- `p_move_in  in  2`: player move selection. Sampled only on a `go` rising edge in WAIT.
- `p_hp  in  4`: player HP, from `pbs_dp`.
- `AI_hp  in  4`: AI HP, from `pbs_dp`.
- `p_move  out  2`: latched player move, to `pbs_dp.p_move`.
- `actr  out  1`: 0 selects the player move, 1 selects the AI RNG move.
- `target  out  1`: 0 targets the player's HP, 1 targets the AI's HP.
- `app_dmg  out  1`: one-cycle damage-apply strobe.
- `stop  out  1`: freezes the `pbs_dp` RNGs.
- `dp_rst_n  out  1`: active-low reset to `pbs_dp`.
- `busy  out  1`: high in every state except WAIT, WIN and LOSE.
- `p_win  out  1`: high in WIN.
- `ai_win  out  1`: high in LOSE.
- `turn_cnt  out  8`: number of completed full turns.

## Operation
- Moore FSM. Outputs are decoded from the state register; `p_move` and `turn_cnt` are registers.
- `go_q` is the registered `go`. `go_rise = go & ~go_q`. A `go` held high triggers once only.
- States and the outputs each one drives:
  - INIT: `dp_rst_n`=0, all other controls 0. Lasts 1 cycle, then WAIT.
  - WAIT: all controls 0. On `go_rise`: latch `p_move` ← `p_move_in`, go to P_SEL.
  - P_SEL: `actr`=0, `target`=1. Stays `SETTLE_CYCLES` cycles (settle counter), then P_HIT.
  - P_HIT: `actr`=0, `target`=1, `app_dmg`=1. Lasts 1 cycle, then P_CHK.
  - P_CHK: `actr`=0, `target`=1. If `AI_hp`==0, go to WIN; else AI_SEL.
  - AI_SEL: `actr`=1, `target`=0, `stop`=1. Stays `SETTLE_CYCLES` cycles, then AI_HIT.
  - AI_HIT: `actr`=1, `target`=0, `stop`=1, `app_dmg`=1. Lasts 1 cycle, then AI_CHK.
  - AI_CHK: `actr`=1, `target`=0, `stop`=1. `turn_cnt` increments (saturates at 255). If `p_hp`==0, go to LOSE; else WAIT.
  - WIN / LOSE: all controls 0, `p_win` or `ai_win` = 1. On `go_rise`, go to INIT, and `turn_cnt` is cleared.
- `target` and `actr` never change in the same cycle that `app_dmg`=1. They are constant across each SEL/HIT/CHK group.
- `go` is ignored while `busy`=1. A rising edge during `busy` is not queued.
- The HP check in CHK sees the value the datapath wrote on the edge that ended HIT.
- If the player's hit brings `AI_hp` to 0, the AI phase is skipped.
- Illegal state encodings go to INIT.

## Timing
- Reset (`rst`=1 at an edge) gives, the next cycle: state INIT, `dp_rst_n`=0, `actr`=`target`=`app_dmg`=`stop`=0, `p_move`=0, `turn_cnt`=0, `p_win`=`ai_win`=0, `busy`=1 (INIT counts as busy).
- Reset mid-turn: the FSM aborts immediately. Any pending `app_dmg` is not issued, and the datapath is re-reset via INIT.
- Reset has priority over `go`.
- With `go_rise` in WAIT at cycle n and S=`SETTLE_CYCLES`:
  - P_SEL: cycles n+1 … n+S
  - P_HIT: n+S+1
  - P_CHK: n+S+2
  - AI_SEL: n+S+3 … n+2S+2
  - AI_HIT: n+2S+3
  - AI_CHK: n+2S+4
  - Back in WAIT: n+2S+5 (that is n+9 for S=2).
- If the player's hit kills the AI, the FSM is in WIN at n+S+3.
- `stop` is high for exactly S+2 cycles per turn.

## Test plan
- Reset: hold `rst`=1 for 3 cycles, then release → INIT for 1 cycle with `dp_rst_n`=0, then WAIT; all outputs 0; `turn_cnt`=0.
- Normal turn, S=2, bench HP stub never reaching 0:
  - Stimulus: `p_move_in`=2'b10, pulse `go`.
  - Required: `p_move`=2'b10; `app_dmg` high exactly at n+3 with `target`=1, `actr`=0; `app_dmg` high exactly at n+7 with `target`=0, `actr`=1, `stop`=1; WAIT at n+9; `turn_cnt`=1.
- Player win: stub sets `AI_hp`=0 after P_HIT → WIN at n+5, `p_win`=1, no second `app_dmg`, `turn_cnt` unchanged.
- AI win: stub sets `p_hp`=0 after AI_HIT → LOSE at n+9, `ai_win`=1. Then pulse `go` → INIT, `turn_cnt`=0.
- Held and ignored `go`:
  - `go` held high for 20 cycles → exactly one turn runs.
  - Extra `go` pulses during `busy` → ignored.
  - `p_move_in` changing mid-turn → `p_move` unchanged.
- `rst` asserted during AI_SEL → `stop`=0 and `app_dmg`=0 the next cycle, state INIT; 256 completed turns → `turn_cnt` saturates at 255.
